// File: rtl/noc_pkg.sv
// Shared types and constants for the four-input round-robin arbiter-merge.
package noc_pkg;

    localparam int unsigned PKT_WIDTH  = 33;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned REQ_IDW    = 2;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef logic [PKT_WIDTH-1:0] pkt_t;
    typedef logic [REQ_IDW-1:0]   req_id_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // Buffered packet together with the requester it came from.
    typedef struct packed {
        req_id_t src;
        pkt_t    data;
    } entry_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry packet buffer; head is read straight from the storage registers.
module fifo2
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  entry_t     wdata_i,
    output entry_t     head_o,
    output logic [1:0] count_o
);

    entry_t     mem_q [FIFO_DEPTH];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_push = push_i && (count_q != 2'(FIFO_DEPTH));
        do_pop  = pop_i && (count_q != 2'd0);
        head_d  = head_q ^ do_pop;
        tail_d  = tail_q ^ do_push;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[tail_q] <= wdata_i;
            end
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way rotating-priority selector; scan starts at ptr_i and wraps.
module rr_arbiter4
    import noc_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  req_id_t            ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_c_o,
    output req_id_t            winner_c_o
);

    req_id_t scan_idx;
    logic    found;

    always_comb begin
        grant_c_o  = '0;
        winner_c_o = '0;
        scan_idx   = '0;
        found      = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = ptr_i + REQ_IDW'(k);
            if (!found && req_i[scan_idx]) begin
                found      = 1'b1;
                winner_c_o = scan_idx;
            end
        end
        if (enable_i && found) begin
            grant_c_o[winner_c_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_merge_four.sv
// Round-robin merge of four requesters into one buffered, source-tagged output.
module rr_arbiter_merge_four
    import noc_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           in_valid,
    output logic [NUM_REQ-1:0]           in_ready,
    input  logic [NUM_REQ*PKT_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output pkt_t                         out_data,
    output req_id_t                      out_src,
    output logic [NUM_REQ*CNT_W-1:0]     grant_cnt
);

    req_id_t            ptr_q, ptr_d;
    cnt_t               cnt_q [NUM_REQ];
    cnt_t               cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] grant_c;
    req_id_t            winner_c;
    logic               arb_en_c;
    logic               push_c;
    logic               pop_c;
    pkt_t               win_pkt_c;
    entry_t             head;
    logic [1:0]         fifo_count;

    // Ready depends only on occupancy, never on out_ready; reset forces it low.
    assign arb_en_c = rst_n && (fifo_count != 2'(FIFO_DEPTH));

    rr_arbiter4 u_arb (
        .req_i      (in_valid),
        .ptr_i      (ptr_q),
        .enable_i   (arb_en_c),
        .grant_c_o  (grant_c),
        .winner_c_o (winner_c)
    );

    assign in_ready = grant_c;
    assign push_c   = |grant_c;
    assign pop_c    = out_valid && out_ready;

    always_comb begin
        win_pkt_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                win_pkt_c = in_data[i*PKT_WIDTH +: PKT_WIDTH];
            end
        end
    end

    fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i ('{src: winner_c, data: win_pkt_c}),
        .head_o  (head),
        .count_o (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head.data;
    assign out_src   = head.src;

    // Pointer moves past the winner only on an accepted packet.
    always_comb begin
        ptr_d = ptr_q;
        if (push_c) begin
            ptr_d = winner_c + REQ_IDW'(1);
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = grant_c[i] ? sat_inc(cnt_q[i]) : cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_rr_arbiter_merge_four.sv
// Directed scoreboard bench for rr_arbiter_merge_four.
module tb_rr_arbiter_merge_four;

    typedef struct packed {
        logic [1:0]  src;
        logic [32:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [131:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [32:0]  out_data;
    logic [1:0]   out_src;
    logic [63:0]  grant_cnt;

    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    rr_arbiter_merge_four dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Requester i carries {1, tag, 0, i} so every packet is distinguishable.
    function automatic logic [131:0] pat(input int tag);
        logic [131:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            d[i*33 +: 33] = {1'b1, 16'(tag), 14'd0, 2'(i)};
        end
        return d;
    endfunction

    // Drive one cycle at posedge+1, check ready, queue the expected output.
    task automatic step(input string name, input logic [3:0] v, input logic rdy,
                        input logic [131:0] d, input logic [3:0] exp_rdy);
        in_valid  = v;
        out_ready = rdy;
        in_data   = d;
        #1;
        chk({name, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                sb_q.push_back({2'(i), d[i*33 +: 33]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_in_ready"},  64'(in_ready),  64'd0);
        chk({name, "_grant_cnt"}, grant_cnt,      64'd0);
        chk({name, "_out_src"},   64'(out_src),   64'd0);
        chk({name, "_out_data"},  64'(out_data),  64'd0);
        sb_q.delete();
        in_valid  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual src=%0d data=%0h required=no output",
                         out_src, out_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_src",  64'(out_src),  64'(mon_e.src));
                chk("out_data", 64'(out_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        logic [131:0] d;
        logic [63:0]  gc;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        do_reset("reset0");

        // Single requester 2
        d = '0;
        d[2*33 +: 33] = 33'h1_0000_00AA;
        step("single", 4'b0100, 1'b1, d, 4'b0100);
        step("single_idle", 4'b0000, 1'b1, '0, 4'b0000);

        // ptr is now 3: wrap from 3 to 0
        step("wrap3", 4'b1001, 1'b1, pat(1), 4'b1000);
        step("wrap0", 4'b1001, 1'b1, pat(2), 4'b0001);
        step("wrap_idle", 4'b0000, 1'b1, '0, 4'b0000);

        do_reset("reset1");

        // All four continuously valid
        for (int k = 0; k < 8; k++) begin
            step("all4", 4'b1111, 1'b1, pat(10 + k), 4'(1 << (k % 4)));
        end
        step("all4_idle", 4'b0000, 1'b1, '0, 4'b0000);
        chk("grant_cnt_equal", grant_cnt, {4{16'd2}});

        // Back-pressure: two accepts then stall
        step("bp1", 4'b1111, 1'b0, pat(20), 4'b0001);
        step("bp2", 4'b1111, 1'b0, pat(21), 4'b0010);
        step("bp3", 4'b1111, 1'b0, pat(22), 4'b0000);
        d = pat(20);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_src",   64'(out_src),   64'd0);
        chk("hold_data",  64'(out_data),  64'(d[32:0]));
        step("bp4", 4'b1111, 1'b0, pat(23), 4'b0000);
        step("bp_pop_full", 4'b1111, 1'b1, pat(24), 4'b0000);
        step("bp_resume", 4'b1111, 1'b1, pat(25), 4'b0100);
        step("bp_idle", 4'b0000, 1'b1, '0, 4'b0000);

        // ptr is 3: fill to two entries, then reset mid-stream
        step("mid1", 4'b1111, 1'b0, pat(30), 4'b1000);
        step("mid2", 4'b1111, 1'b0, pat(31), 4'b0001);
        do_reset("midreset");
        step("post_reset", 4'b0110, 1'b1, pat(32), 4'b0010);
        step("post_idle", 4'b0000, 1'b1, '0, 4'b0000);

        // Saturation of requester 1's counter
        do_reset("reset3");
        for (int n = 0; n < 65534; n++) begin
            step("sat_fill", 4'b0010, 1'b1, pat(n), 4'b0010);
        end
        gc = grant_cnt;
        chk("cnt_fffe", 64'(gc[31:16]), 64'hFFFE);
        for (int n = 0; n < 3; n++) begin
            step("sat_top", 4'b0010, 1'b1, pat(100 + n), 4'b0010);
        end
        chk("cnt_sat", grant_cnt, 64'h0000_0000_FFFF_0000);
        step("sat_idle", 4'b0000, 1'b1, '0, 4'b0000);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
